// File: rtl/uart_echo_tester.sv
// Board self-test initiator: streams a byte pattern into a uart_tx and checks each echo
// from a uart_rx against (sent ^ XOR_MASK). Define LFSR_PATTERN_EN for an LFSR pattern.
module uart_echo_tester #(
    parameter int unsigned CLKFREQ     = 12000000,
    parameter int unsigned TIMEOUT_CYC = CLKFREQ / 100,
    parameter logic [7:0]  XOR_MASK    = 8'h20,
    parameter int unsigned NUM_BYTES   = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        tx_send,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        running,
    output logic        done,
    output logic [15:0] pass_cnt,
    output logic [15:0] err_cnt,
    output logic [15:0] last_err
);

`ifdef LFSR_PATTERN_EN
    localparam logic [7:0] PatSeed = 8'h01;
`else
    localparam logic [7:0] PatSeed = 8'h00;
`endif

    localparam logic [23:0] TmoLast    = 24'(TIMEOUT_CYC - 1);
    localparam logic [15:0] IdxLast    = 16'(NUM_BYTES - 1);
    localparam bit          RunForever = (NUM_BYTES == 0);

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWaitTx,
        StWaitRx,
        StCheck,
        StNext,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  pat_q, pat_d;
    logic [15:0] idx_q, idx_d;
    logic [23:0] tmo_q, tmo_d;
    logic        pend_q, pend_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_prev_q;
    logic [15:0] pass_q, pass_d;
    logic [15:0] err_q, err_d;
    logic [15:0] last_q, last_d;
    logic        rx_evt;
    logic [7:0]  exp_byte;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] next_pat(input logic [7:0] p);
`ifdef LFSR_PATTERN_EN
        // Fibonacci form of x^8+x^6+x^5+x^4+1, shifting toward the MSB.
        return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
`else
        return p + 8'd1;
`endif
    endfunction

    assign rx_evt   = rx_ready & ~rx_prev_q;
    assign exp_byte = pat_q ^ XOR_MASK;

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        idx_d     = idx_q;
        tmo_d     = '0;
        pend_d    = pend_q;
        rx_byte_d = rx_byte_q;
        pass_d    = pass_q;
        err_d     = err_q;
        last_d    = last_q;
        tx_send   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSend;
                    pat_d   = PatSeed;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                    pass_d  = '0;
                    err_d   = '0;
                    last_d  = '0;
                end
                if (rx_evt) begin
                    err_d  = sat_inc(err_d);
                    last_d = {8'h00, rx_data};
                end
            end
            StSend: begin
                tx_send = 1'b1;
                if (tx_busy) begin
                    state_d = StWaitTx;
                end
                if (rx_evt) begin
                    err_d  = sat_inc(err_q);
                    last_d = {8'h00, rx_data};
                end
            end
            StWaitTx: begin
                // Fast echoes can arrive before uart_tx reports idle; hold them for WAIT_RX.
                if (rx_evt) begin
                    pend_d    = 1'b1;
                    rx_byte_d = rx_data;
                end
                if (!tx_busy) begin
                    state_d = StWaitRx;
                end
            end
            StWaitRx: begin
                if (pend_q || rx_evt) begin
                    state_d = StCheck;
                    pend_d  = 1'b0;
                    if (!pend_q) begin
                        rx_byte_d = rx_data;
                    end
                end else if (tmo_q == TmoLast) begin
                    state_d = StNext;
                    err_d   = sat_inc(err_q);
                    last_d  = {exp_byte, 8'h00};
                end else begin
                    tmo_d = tmo_q + 24'd1;
                end
            end
            StCheck: begin
                state_d = StNext;
                if (rx_byte_q == exp_byte) begin
                    pass_d = sat_inc(pass_q);
                end else begin
                    err_d  = sat_inc(err_q);
                    last_d = {exp_byte, rx_byte_q};
                end
            end
            StNext: begin
                pat_d = next_pat(pat_q);
                idx_d = idx_q + 16'd1;
                if (!RunForever && (idx_q == IdxLast)) begin
                    state_d = StDone;
                end else begin
                    state_d = StSend;
                end
            end
            StDone: begin
                if (rx_evt) begin
                    err_d  = sat_inc(err_q);
                    last_d = {8'h00, rx_data};
                end
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pat_q     <= PatSeed;
            idx_q     <= '0;
            tmo_q     <= '0;
            pend_q    <= 1'b0;
            rx_byte_q <= '0;
            rx_prev_q <= 1'b0;
            pass_q    <= '0;
            err_q     <= '0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            pend_q    <= pend_d;
            rx_byte_q <= rx_byte_d;
            rx_prev_q <= rx_ready;
            pass_q    <= pass_d;
            err_q     <= err_d;
            last_q    <= last_d;
        end
    end

    assign tx_data  = pat_q;
    assign running  = (state_q != StIdle) && (state_q != StDone);
    assign done     = (state_q == StDone);
    assign pass_cnt = pass_q;
    assign err_cnt  = err_q;
    assign last_err = last_q;

endmodule

// File: tb/tb_uart_echo_tester.sv
// Bench for uart_echo_tester: table of echo-model runs plus hand sequences for stray bytes,
// timeout timing and reset during SEND.
module tb_uart_echo_tester;

    localparam int unsigned NB  = 4;
    localparam int unsigned TMO = 100;

`ifdef LFSR_PATTERN_EN
    localparam logic [7:0] SEED = 8'h01;
`else
    localparam logic [7:0] SEED = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        running;
    logic        done;
    logic [15:0] pass_cnt;
    logic [15:0] err_cnt;
    logic [15:0] last_err;

    always #5 clk = ~clk;

    uart_echo_tester #(
        .TIMEOUT_CYC(TMO),
        .XOR_MASK   (8'h20),
        .NUM_BYTES  (NB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .tx_send (tx_send),
        .tx_data (tx_data),
        .tx_busy (tx_busy),
        .rx_ready(rx_ready),
        .rx_data (rx_data),
        .running (running),
        .done    (done),
        .pass_cnt(pass_cnt),
        .err_cnt (err_cnt),
        .last_err(last_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act !== expv) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end else begin
            n_pass++;
        end
    endtask

    // Expected pattern bytes, written out by hand.
    function automatic logic [7:0] exp_byte(input int i);
`ifdef LFSR_PATTERN_EN
        case (i)
            0:       return 8'h01;
            1:       return 8'h02;
            2:       return 8'h04;
            default: return 8'h08;
        endcase
`else
        case (i)
            0:       return 8'h00;
            1:       return 8'h01;
            2:       return 8'h02;
            default: return 8'h03;
        endcase
`endif
    endfunction

    // Echo model: acknowledges each tx_send with a short busy, echoes tx^20 ~50 cycles later.
    int         corrupt_idx = -1;
    int         drop_idx    = -1;
    int         latch_idx   = -1;
    bit         echo_en     = 1'b0;
    int         run_base    = 0;
    int         sent_n      = 0;
    logic [7:0] sent [64];

    initial begin : echo_model
        int         idx;
        logic [7:0] b;
        tx_busy  = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (echo_en && tx_send) begin
                b   = tx_data;
                idx = sent_n - run_base;
                sent[sent_n % 64] = b;
                sent_n++;
                tx_busy = 1'b1;
                if (idx == latch_idx) begin
                    repeat (5) @(negedge clk);
                    rx_data  = b ^ 8'h20;
                    rx_ready = 1'b1;
                    @(negedge clk);
                    rx_ready = 1'b0;
                    repeat (10) @(negedge clk);
                    tx_busy = 1'b0;
                end else begin
                    repeat (3) @(negedge clk);
                    tx_busy = 1'b0;
                    repeat (50) @(negedge clk);
                    if (idx != drop_idx) begin
                        rx_data  = (idx == corrupt_idx) ? 8'h00 : (b ^ 8'h20);
                        rx_ready = 1'b1;
                        @(negedge clk);
                        rx_ready = 1'b0;
                    end
                end
            end
        end
    end

    typedef struct {
        int          corrupt_idx;
        int          drop_idx;
        int          latch_idx;
        logic [15:0] exp_pass;
        logic [15:0] exp_err;
        logic [15:0] exp_last;
    } case_t;

    case_t cases [4];

    task automatic run_case(input int k);
        int waited;
        corrupt_idx = cases[k].corrupt_idx;
        drop_idx    = cases[k].drop_idx;
        latch_idx   = cases[k].latch_idx;
        run_base    = sent_n;
        echo_en     = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while (!done && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        chk($sformatf("case%0d_done", k), {31'd0, done}, 32'd1);
        chk($sformatf("case%0d_running", k), {31'd0, running}, 32'd0);
        chk($sformatf("case%0d_pass_cnt", k), {16'd0, pass_cnt}, {16'd0, cases[k].exp_pass});
        chk($sformatf("case%0d_err_cnt", k), {16'd0, err_cnt}, {16'd0, cases[k].exp_err});
        chk($sformatf("case%0d_last_err", k), {16'd0, last_err}, {16'd0, cases[k].exp_last});
        chk($sformatf("case%0d_bytes_sent", k), 32'(sent_n - run_base), NB);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("case%0d_byte%0d", k, i), {24'd0, sent[(run_base + i) % 64]},
                {24'd0, exp_byte(i)});
        end
        echo_en     = 1'b0;
        corrupt_idx = -1;
        drop_idx    = -1;
        latch_idx   = -1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        cases[0] = '{-1, -1, -1, 16'd4, 16'd0, 16'h0000};
        cases[1] = '{-1, -1,  0, 16'd4, 16'd0, 16'h0000};
        cases[2] = '{ 2, -1, -1, 16'd3, 16'd1, {exp_byte(2) ^ 8'h20, 8'h00}};
        cases[3] = '{-1,  1, -1, 16'd3, 16'd1, {exp_byte(1) ^ 8'h20, 8'h00}};

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_send", {31'd0, tx_send}, 32'd0);
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass_cnt", {16'd0, pass_cnt}, 32'd0);
        chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        chk("rst_last_err", {16'd0, last_err}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, {24'd0, SEED});
        rst_n = 1'b1;
        @(negedge clk);

        // Stray byte in IDLE, held high for several cycles: exactly one error.
        rx_data  = 8'h55;
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
        chk("stray_err_cnt", {16'd0, err_cnt}, 32'd1);
        chk("stray_last_err", {16'd0, last_err}, 32'h0055);
        chk("stray_running", {31'd0, running}, 32'd0);
        chk("stray_done", {31'd0, done}, 32'd0);
        chk("stray_tx_send", {31'd0, tx_send}, 32'd0);

        for (int k = 0; k < 4; k++) begin
            run_case(k);
        end

        // Timeout timing with no echo: error lands after exactly TMO cycles in WAIT_RX.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("tmo_send", {31'd0, tx_send}, 32'd1);
        tx_busy = 1'b1;
        @(negedge clk);
        tx_busy = 1'b0;
        repeat (TMO) @(negedge clk);
        chk("tmo_early_err", {16'd0, err_cnt}, 32'd0);
        @(negedge clk);
        chk("tmo_err_cnt", {16'd0, err_cnt}, 32'd1);
        chk("tmo_last_err", {16'd0, last_err}, {16'd0, SEED ^ 8'h20, 8'h00});
        chk("tmo_pass_cnt", {16'd0, pass_cnt}, 32'd0);
        @(negedge clk);
        chk("next_send", {31'd0, tx_send}, 32'd1);
        chk("next_tx_data", {24'd0, tx_data}, {24'd0, exp_byte(1)});
        chk("next_running", {31'd0, running}, 32'd1);

        // Asynchronous reset during SEND.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx_send", {31'd0, tx_send}, 32'd0);
        chk("arst_running", {31'd0, running}, 32'd0);
        chk("arst_tx_data", {24'd0, tx_data}, {24'd0, SEED});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Restart after reset begins again from the seed.
        run_case(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
